// File: rtl/fft8_pkg.sv
// Shared constants and index helpers for the fft8 input framer and its sample banks.
package fft8_pkg;

  localparam int N_POINTS = 8;
  localparam int IDX_W    = 3;
  localparam int SAMPLE_W = 32;

  // Packed complex sample layout: {real, imag}, 16-bit float halves.
  localparam int REAL_MSB = 31;
  localparam int REAL_LSB = 16;
  localparam int IMAG_MSB = 15;
  localparam int IMAG_LSB = 0;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t bitrev3(input idx_t idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/fft8_frame_bank.sv
// One 8-word frame buffer; a single indexed write port, all words readable in parallel.
module fft8_frame_bank
  import fft8_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] words_o [N_POINTS]
);

  logic [DATA_W-1:0] words_q [N_POINTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_POINTS; i++) begin
        words_q[i] <= '0;
      end
    end else if (we) begin
      words_q[widx] <= wdata;
    end
  end

  assign words_o = words_q;

endmodule

// File: rtl/fft8_input_framer.sv
// Ping-pong framer: gathers serial complex samples into 8-word frames and holds
// each frame on out1..out8 until the downstream fft8 stage accepts it.
module fft8_input_framer #(
  parameter int SAMPLE_W    = 32,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  input  logic                s_sop,
  output logic                s_ready,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                frame_err,
  output logic [SAMPLE_W-1:0] out1,
  output logic [SAMPLE_W-1:0] out2,
  output logic [SAMPLE_W-1:0] out3,
  output logic [SAMPLE_W-1:0] out4,
  output logic [SAMPLE_W-1:0] out5,
  output logic [SAMPLE_W-1:0] out6,
  output logic [SAMPLE_W-1:0] out7,
  output logic [SAMPLE_W-1:0] out8
);

  import fft8_pkg::*;

  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_cnt_q, full_cnt_d;
  logic             err_q, err_d;

  logic             accept, restart, complete, consume;
  logic [IDX_W-1:0] widx;
  logic [SAMPLE_W-1:0] bank0_words [N_POINTS];
  logic [SAMPLE_W-1:0] bank1_words [N_POINTS];
  logic [SAMPLE_W-1:0] rd_words    [N_POINTS];

  assign s_ready     = !rst && (full_cnt_q != 2'd2);
  assign frame_valid = (full_cnt_q != 2'd0);
  assign frame_err   = err_q;

  assign accept   = s_valid && s_ready;
  // An s_sop mid-frame drops the partial frame and restarts at index 0.
  assign restart  = accept && s_sop && (wr_idx_q != '0);
  assign complete = accept && !restart && (wr_idx_q == IDX_W'(N_POINTS - 1));
  assign consume  = frame_valid && frame_ready;

  assign widx = restart     ? '0 :
                BIT_REVERSE ? bitrev3(wr_idx_q) : wr_idx_q;

  always_comb begin
    wr_idx_d   = wr_idx_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_cnt_d = full_cnt_q;
    err_d      = restart;

    if (restart) begin
      wr_idx_d = IDX_W'(1);
    end else if (accept) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end

    if (complete) begin
      wr_bank_d = !wr_bank_q;
    end
    if (consume) begin
      rd_bank_d = !rd_bank_q;
    end

    case ({complete, consume})
      2'b10:   full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_cnt_q <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_cnt_q <= full_cnt_d;
      err_q      <= err_d;
    end
  end

  fft8_frame_bank #(.DATA_W(SAMPLE_W)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (accept && !wr_bank_q),
    .widx    (widx),
    .wdata   (s_data),
    .words_o (bank0_words)
  );

  fft8_frame_bank #(.DATA_W(SAMPLE_W)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (accept && wr_bank_q),
    .widx    (widx),
    .wdata   (s_data),
    .words_o (bank1_words)
  );

  // Writes only ever hit the other bank, so the read side stays stable.
  always_comb begin
    for (int k = 0; k < N_POINTS; k++) begin
      rd_words[k] = rd_bank_q ? bank1_words[k] : bank0_words[k];
    end
  end

  assign out1 = rd_words[0];
  assign out2 = rd_words[1];
  assign out3 = rd_words[2];
  assign out4 = rd_words[3];
  assign out5 = rd_words[4];
  assign out6 = rd_words[5];
  assign out7 = rd_words[6];
  assign out8 = rd_words[7];

endmodule

// File: tb/tb_fft8_input_framer.sv
// Bench for fft8_input_framer: natural-order and bit-reversed instances share one
// stimulus stream and are compared against a queue-based frame model.
module tb_fft8_input_framer;
  import fft8_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid, s_sop, frame_ready;

  logic        readyN, validN, errN;
  logic        readyR, validR, errR;
  logic [31:0] outN [8];
  logic [31:0] outR [8];

  int testsRun    = 0;
  int testsFailed = 0;

  typedef logic [31:0] frame_t [8];
  frame_t      frames [$];
  logic [31:0] partial [$];
  logic        errExp;
  logic        outsZeroExp;

  always #5 clk = ~clk;

  fft8_input_framer #(.SAMPLE_W(32), .BIT_REVERSE(1'b0)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop),
    .s_ready(readyN), .frame_valid(validN), .frame_ready(frame_ready), .frame_err(errN),
    .out1(outN[0]), .out2(outN[1]), .out3(outN[2]), .out4(outN[3]),
    .out5(outN[4]), .out6(outN[5]), .out7(outN[6]), .out8(outN[7])
  );

  fft8_input_framer #(.SAMPLE_W(32), .BIT_REVERSE(1'b1)) dutRev (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop),
    .s_ready(readyR), .frame_valid(validR), .frame_ready(frame_ready), .frame_err(errR),
    .out1(outR[0]), .out2(outR[1]), .out3(outR[2]), .out4(outR[3]),
    .out5(outR[4]), .out6(outR[5]), .out7(outR[6]), .out8(outR[7])
  );

  function automatic logic [31:0] mkSample(input logic [15:0] re, input logic [15:0] im);
    logic [31:0] w;
    w = '0;
    w[REAL_MSB:REAL_LSB] = re;
    w[IMAG_MSB:IMAG_LSB] = im;
    return w;
  endfunction

  // Slot j of a bit-reversed frame holds the sample whose index reverses to j.
  function automatic int revIndex(input int j);
    return ((j % 2) * 4) + (((j / 2) % 2) * 2) + ((j / 4) % 2);
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic expReady;
    expReady = !rst && (frames.size() < 2);
    checkEq("s_ready", {31'd0, readyN}, {31'd0, expReady});
    checkEq("s_ready_rev", {31'd0, readyR}, {31'd0, expReady});
    checkEq("frame_valid", {31'd0, validN}, {31'd0, frames.size() != 0});
    checkEq("frame_valid_rev", {31'd0, validR}, {31'd0, frames.size() != 0});
    checkEq("frame_err", {31'd0, errN}, {31'd0, errExp});
    checkEq("frame_err_rev", {31'd0, errR}, {31'd0, errExp});
    if (frames.size() != 0) begin
      for (int k = 0; k < 8; k++) begin
        checkEq($sformatf("out%0d", k + 1), outN[k], frames[0][k]);
        checkEq($sformatf("rev_out%0d", k + 1), outR[k], frames[0][revIndex(k)]);
      end
    end else if (outsZeroExp) begin
      for (int k = 0; k < 8; k++) begin
        checkEq($sformatf("zero_out%0d", k + 1), outN[k], 32'h0);
        checkEq($sformatf("zero_rev_out%0d", k + 1), outR[k], 32'h0);
      end
    end
  endtask

  // Called at a falling edge: drive, check current state, clock, advance the model.
  task automatic applyStimulus(input logic r, input logic v, input logic sop,
                               input logic [31:0] d, input logic fr);
    logic   acc, cons;
    frame_t done;
    rst = r; s_valid = v; s_sop = sop; s_data = d; frame_ready = fr;
    #1;
    checkOutput();
    @(posedge clk);
    if (r) begin
      frames.delete();
      partial.delete();
      errExp      = 1'b0;
      outsZeroExp = 1'b1;
    end else begin
      cons   = (frames.size() != 0) && fr;
      acc    = v && (frames.size() < 2);
      errExp = acc && sop && (partial.size() != 0);
      if (cons) frames.delete(0);
      if (acc) begin
        outsZeroExp = 1'b0;
        if (sop && partial.size() != 0) partial.delete();
        partial.push_back(d);
        if (partial.size() == 8) begin
          for (int k = 0; k < 8; k++) done[k] = partial[k];
          frames.push_back(done);
          partial.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic fr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, fr);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        expValid;
    logic        expReady;
    logic        chkFrame;
  } vec_t;

  initial begin
    vec_t        vecs [10];
    logic [31:0] t1Words [8];
    logic [31:0] stream [24];
    logic [31:0] revExp [8];

    rst = 1'b1; s_valid = 1'b0; s_sop = 1'b0; s_data = '0; frame_ready = 1'b0;
    errExp = 1'b0; outsZeroExp = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // Reset state, with s_ready held low while rst is high.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Test 1: table-driven single frame with frame_ready=1.
    t1Words[0] = mkSample(16'h3c00, 16'h0); t1Words[1] = mkSample(16'h4000, 16'h0);
    t1Words[2] = mkSample(16'h4200, 16'h0); t1Words[3] = mkSample(16'h4400, 16'h0);
    t1Words[4] = mkSample(16'h4400, 16'h0); t1Words[5] = mkSample(16'h4200, 16'h0);
    t1Words[6] = mkSample(16'h4000, 16'h0); t1Words[7] = mkSample(16'h3c00, 16'h0);
    for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, t1Words[i], 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rst = 1'b0;
      #1;
      checkEq($sformatf("t1_valid[%0d]", i), {31'd0, validN}, {31'd0, vecs[i].expValid});
      checkEq($sformatf("t1_ready[%0d]", i), {31'd0, readyN}, {31'd0, vecs[i].expReady});
      if (vecs[i].chkFrame) begin
        for (int k = 0; k < 8; k++) checkEq($sformatf("t1_out%0d", k + 1), outN[k], t1Words[k]);
      end
      applyStimulus(1'b0, vecs[i].v, 1'b0, vecs[i].d, 1'b1);
    end

    // Test 2: three frames back to back.
    for (int i = 0; i < 24; i++) stream[i] = $urandom;
    stream[9] = 32'h40450000;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b0, 1'b1, (i % 8) == 0, stream[i], 1'b1);
      if (i == 15) checkEq("t2_frame2_word2", outN[1], 32'h40450000);
    end
    idle(2, 1'b1);

    // Test 3: backpressure fills both banks, then one consume.
    for (int i = 0; i < 16; i++) begin
      stream[i] = $urandom;
      applyStimulus(1'b0, 1'b1, 1'b0, stream[i], 1'b0);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, $urandom, 1'b0);
    checkEq("t3_held_out1", outN[0], stream[0]);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkEq("t3_ready_restored", {31'd0, readyN}, 32'd1);
    checkEq("t3_frame2_out8", outN[7], stream[15]);
    idle(2, 1'b1);

    // Test 4: early s_sop discards a 5-sample partial frame.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, i == 0, $urandom, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h3c010000, 1'b1);
    checkEq("t4_err_pulse", {31'd0, errN}, 32'd1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, $urandom, 1'b1);
    checkEq("t4_out1", outN[0], 32'h3c010000);
    checkEq("t4_err_cleared", {31'd0, errN}, 32'd0);
    idle(2, 1'b1);

    // Test 5: bit-reversed placement on the second instance.
    revExp[0] = 0; revExp[1] = 4; revExp[2] = 2; revExp[3] = 6;
    revExp[4] = 1; revExp[5] = 5; revExp[6] = 3; revExp[7] = 7;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, i == 0, i, 1'b1);
    for (int k = 0; k < 8; k++) checkEq($sformatf("t5_rev_out%0d", k + 1), outR[k], revExp[k]);
    idle(2, 1'b1);

    // Test 6: reset with one full frame pending and a 3-sample partial.
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1, 1'b0, $urandom, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    checkEq("t6_valid_after_rst", {31'd0, validN}, 32'd0);
    checkEq("t6_out1_after_rst", outN[0], 32'h0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, $urandom, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
